conv_window_ctrl: RTL and testbench

Sequencer for the 28×28 image line buffer and 5×5 window generator. It accepts a pixel stream with a valid/ready handshake and drives the buffer shift enable. It tracks the row and column of each accepted pixel, and emits a window-valid/ready handshake to the downstream convolution engine only when the 5×5 window lies fully inside the image. It sits between the pixel source and the window buffer/conv datapath, and owns frame start, abort and frame-done sequencing.

---
 rtl/conv_window_ctrl_pkg.sv | 18 +
 rtl/conv_window_ctrl_counter.sv | 41 ++++
 rtl/conv_window_ctrl.sv | 179 +++++++++++++++++
 tb/tb_conv_window_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/conv_window_ctrl_pkg.sv
// Shared state type and default geometry for the 5x5 convolution window sequencer.
// Sits with the network_params constants so every conv block agrees on frame size.
package conv_window_ctrl_pkg;

    // network_params: default feature-map geometry
    localparam int NET_IMG_W = 28;
    localparam int NET_IMG_H = 28;
    localparam int NET_K     = 5;
    localparam int NET_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } win_state_e;

endpackage

// File: rtl/conv_window_ctrl_counter.sv
// Parameterised mod-N counter with enable, synchronous clear and a wrap strobe.
// Used by conv_window_ctrl for the pixel column and row.
module win_mod_counter #(
    parameter int N = 28,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         wrap_o
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Wrap fires on the enabled step that rolls the count back to zero.
    assign wrap_o = en_i & (cnt_q == LAST) & ~clr_i;
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/conv_window_ctrl.sv
// Sequencer for the image line buffer / KxK window generator and its downstream handshake.
// Optional stall statistics are built only when WIN_CTRL_STATS_EN is defined.
module conv_window_ctrl
    import conv_window_ctrl_pkg::*;
#(
    parameter int IMG_W = NET_IMG_W,
    parameter int IMG_H = NET_IMG_H,
    parameter int K     = NET_K,
    parameter int CNT_W = NET_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     pix_valid,
    output logic                     pix_ready,
    output logic                     shift_en,
    output logic                     win_valid,
    input  logic                     win_ready,
    output logic [$clog2(IMG_H)-1:0] win_row,
    output logic [$clog2(IMG_W)-1:0] win_col,
    output logic                     busy,
    output logic                     frame_done,
    output logic [CNT_W-1:0]         stall_cnt
);

    localparam int RW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);

    win_state_e state_q;
    win_state_e state_d;

    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic          col_wrap;
    logic          row_wrap;
    logic          frame_start;
    logic          cnt_clr;
    logic          qualify;

    logic          win_valid_q;
    logic          win_valid_d;
    logic [RW-1:0] win_row_q;
    logic [RW-1:0] win_row_d;
    logic [CW-1:0] win_col_q;
    logic [CW-1:0] win_col_d;

    // A new pixel is only taken when the held window is free or leaving this cycle.
    assign pix_ready   = (state_q == ST_RUN) & ~abort & (~win_valid_q | win_ready);
    assign shift_en    = pix_valid & pix_ready;
    assign frame_start = (state_q == ST_IDLE) & start & ~abort;
    assign cnt_clr     = frame_start | abort;

    win_mod_counter #(
        .N (IMG_W),
        .W (CW)
    ) u_col_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (cnt_clr),
        .en_i   (shift_en),
        .cnt_o  (col),
        .wrap_o (col_wrap)
    );

    win_mod_counter #(
        .N (IMG_H),
        .W (RW)
    ) u_row_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (cnt_clr),
        .en_i   (shift_en & col_wrap),
        .cnt_o  (row),
        .wrap_o (row_wrap)
    );

    // The window's bottom-right corner is the pixel being shifted in.
    assign qualify = shift_en & (row >= RW'(K - 1)) & (col >= CW'(K - 1));

    always_comb begin
        state_d    = state_q;
        busy       = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (row_wrap) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (~win_valid_q | win_ready) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                frame_done = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort) begin
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        win_valid_d = win_valid_q;
        win_row_d   = win_row_q;
        win_col_d   = win_col_q;
        if (abort) begin
            win_valid_d = 1'b0;
            win_row_d   = '0;
            win_col_d   = '0;
        end else if (qualify) begin
            win_valid_d = 1'b1;
            win_row_d   = row - RW'(K - 1);
            win_col_d   = col - CW'(K - 1);
        end else if (win_ready) begin
            win_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            win_valid_q <= 1'b0;
            win_row_q   <= '0;
            win_col_q   <= '0;
        end else begin
            state_q     <= state_d;
            win_valid_q <= win_valid_d;
            win_row_q   <= win_row_d;
            win_col_q   <= win_col_d;
        end
    end

    assign win_valid = win_valid_q;
    assign win_row   = win_row_q;
    assign win_col   = win_col_q;

`ifdef WIN_CTRL_STATS_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] stall_d;

    always_comb begin
        stall_d = stall_q;
        if (cnt_clr) begin
            stall_d = '0;
        end else if ((state_q == ST_RUN) & pix_valid & ~pix_ready) begin
            stall_d = sat_inc(stall_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Scoreboard bench for conv_window_ctrl: windows queued on accept, checked on handshake.
`timescale 1ns/1ps
module tb_conv_window_ctrl;

    localparam int IMG_W = 28;
    localparam int IMG_H = 28;
    localparam int K     = 5;
    localparam int CNT_W = 16;
    localparam int NWIN  = (IMG_W - K + 1) * (IMG_H - K + 1);
`ifdef WIN_CTRL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, start, abort, pix_valid, win_ready;
    logic pix_ready, shift_en, win_valid, busy, frame_done;
    logic [4:0] win_row, win_col;
    logic [CNT_W-1:0] stall_cnt;

    always #5 clk = ~clk;

    conv_window_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .shift_en(shift_en),
        .win_valid(win_valid), .win_ready(win_ready),
        .win_row(win_row), .win_col(win_col),
        .busy(busy), .frame_done(frame_done), .stall_cnt(stall_cnt)
    );

    typedef struct { int r; int c; } win_t;
    win_t exp_q[$];

    int checks = 0;
    int errors = 0;

    // reference model state: 0 idle, 1 run, 2 drain, 3 done
    int m_state, m_row, m_col, m_stall, m_acc;
    bit m_wv;
    int cyc = 0, cyc_last_acc = 0;
    int win_cnt, done_seen, last_r, last_c, last_acc;
    bit lat_chk, edge_chk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_row = 0; m_col = 0; m_stall = 0; m_acc = 0; m_wv = 1'b0;
        exp_q.delete();
    endtask

    // One clock: inputs already driven just after the falling edge.
    task automatic step();
        bit e_pr, acc, qual, wv_old;
        win_t w;
        #1;
        e_pr = (m_state == 1) && !abort && (!m_wv || win_ready);
        check("pix_ready", pix_ready, e_pr);
        check("shift_en", shift_en, pix_valid && e_pr);
        check("win_valid", win_valid, m_wv);
        check("busy", busy, (m_state == 1) || (m_state == 2));
        check("frame_done", frame_done, m_state == 3);
        check("stall_cnt", stall_cnt, STATS ? m_stall : 0);
        if (win_valid) begin
            if (exp_q.size() == 0) begin
                check("win_unexpected", win_valid, 0);
            end else begin
                w = exp_q[0];
                check("win_row", win_row, w.r);
                check("win_col", win_col, w.c);
                if (win_ready) begin
                    void'(exp_q.pop_front());
                    check("win_col_range", win_col <= 5'(IMG_W - K), 1);
                    if (edge_chk && win_cnt == 0) check("first_win_acc", m_acc, K * IMG_W - IMG_W + K);
                    if (edge_chk && w.c == 0 && w.r > 0 && last_c == IMG_W - K)
                        check("col_wrap_accepts", m_acc - last_acc, K);
                    last_r = w.r; last_c = w.c; last_acc = m_acc;
                    win_cnt++;
                end
            end
        end
        if (frame_done) begin
            done_seen++;
            if (lat_chk) check("done_latency", cyc - cyc_last_acc, 2);
        end
        acc    = pix_valid && e_pr;
        qual   = acc && (m_row >= K - 1) && (m_col >= K - 1);
        wv_old = m_wv;
        if (abort) begin
            m_state = 0; m_wv = 1'b0; m_stall = 0; m_row = 0; m_col = 0;
            exp_q.delete();
        end else begin
            if (m_state == 1 && pix_valid && !e_pr && m_stall < (1 << CNT_W) - 1) m_stall++;
            if (qual) begin
                exp_q.push_back('{m_row - K + 1, m_col - K + 1});
                m_wv = 1'b1;
            end else if (win_ready) begin
                m_wv = 1'b0;
            end
            case (m_state)
                0: if (start) begin m_state = 1; m_row = 0; m_col = 0; m_stall = 0; m_acc = 0; end
                1: if (acc) begin
                       m_acc++;
                       cyc_last_acc = cyc;
                       if (m_col == IMG_W - 1) begin
                           m_col = 0;
                           if (m_row == IMG_H - 1) begin m_row = 0; m_state = 2; end
                           else m_row++;
                       end else m_col++;
                   end
                2: if (!wv_old || win_ready) m_state = 3;
                default: m_state = 0;
            endcase
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    // mode 0: free-flowing with a stray start; mode 1: 10-cycle hold then random traffic
    task automatic run_frame(input int mode, input int abort_at);
        int hold;
        bit held, aborted;
        hold = 0; held = 1'b0; aborted = 1'b0;
        abort = 1'b0; pix_valid = 1'b0; win_ready = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        win_cnt = 0; done_seen = 0; last_r = -1; last_c = -1; last_acc = 0;
        lat_chk  = (mode == 0) && (abort_at == 0);
        edge_chk = lat_chk;
        for (int n = 0; n < 6000 && m_state != 0; n++) begin
            pix_valid = 1'b1; win_ready = 1'b1; start = 1'b0; abort = 1'b0;
            if (mode == 0) start = (m_acc == 50);
            if (mode == 1) begin
                if (hold == 10 && !held) begin
                    held = 1'b1;
                    #1;
                    check("hold_stall_cnt", stall_cnt, STATS ? 10 : 0);
                end
                if (m_wv && hold < 10) begin
                    win_ready = 1'b0;
                    hold++;
                end else if (held) begin
                    pix_valid = ($urandom_range(0, 3) != 0);
                    win_ready = ($urandom_range(0, 2) != 0);
                end
            end
            if (abort_at > 0 && m_acc == abort_at && !aborted) begin
                abort = 1'b1; pix_valid = 1'b0; aborted = 1'b1;
            end
            step();
        end
        abort = 1'b0; start = 1'b0;
        if (abort_at == 0) begin
            check("frame_windows", win_cnt, NWIN);
            check("frame_done_count", done_seen, 1);
        end else begin
            #1;
            check("abort_win_valid", win_valid, 0);
            check("abort_busy", busy, 0);
            @(negedge clk);
            pix_valid = 1'b1;
            for (int i = 0; i < 4; i++) step();
            check("abort_no_done", done_seen, 0);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; pix_valid = 1'b1; win_ready = 1'b0;
        model_reset();
        @(negedge clk); @(negedge clk);
        #1;
        check("rst_pix_ready", pix_ready, 0);
        check("rst_shift_en", shift_en, 0);
        check("rst_win_valid", win_valid, 0);
        check("rst_win_row", win_row, 0);
        check("rst_win_col", win_col, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_stall_cnt", stall_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) step();

        run_frame(0, 0);
        run_frame(1, 0);
        run_frame(0, 300);
        run_frame(0, 0);

        // asynchronous reset while a window is pending
        start = 1'b1; step(); start = 1'b0;
        for (int n = 0; n < 2000 && !(m_acc >= 200 && m_wv); n++) begin
            pix_valid = 1'b1; win_ready = 1'b1; step();
        end
        win_ready = 1'b0;
        #1;
        check("pre_rst_win_valid", win_valid, 1);
        #1;
        rst = 1'b1;
        #1;
        check("arst_pix_ready", pix_ready, 0);
        check("arst_shift_en", shift_en, 0);
        check("arst_win_valid", win_valid, 0);
        check("arst_win_row", win_row, 0);
        check("arst_win_col", win_col, 0);
        check("arst_busy", busy, 0);
        check("arst_frame_done", frame_done, 0);
        check("arst_stall_cnt", stall_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        pix_valid = 1'b1; win_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();

        run_frame(0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
